sensor_timer_mc: RTL
====================

// Module: sensor_timer_mc
// PURPOSE
//  Multi-channel Avalon-MM interval timer for sensor-node scheduling (sample, radio, watchdog slots).
//  CHANNELS independent down-counters, each with prescaler, one-shot/continuous mode and IRQ enable.
//  Adds per-channel timeout pulses, an aggregated irq and a pending-IRQ summary register.
//  Sits on the system Avalon bus beside the CPU, one slave port, one interrupt line.
// PARAMETERS
//  CHANNELS      2       number of timer channels (1..8)
//  COUNT_W       32      counter/period width (8..32)
//  PRESC_W       16      prescaler width (1..16)
//  ADDR_W        4       word address width; requires 4*CHANNELS+2 <= 2**ADDR_W
//  RESET_PERIOD  99999   PERIOD reset value, all channels
// PORTS
//  clk         in   1         system clock
//  reset_n     in   1         asynchronous, active-low reset
//  address     in   ADDR_W    word address
//  chipselect  in   1         slave select
//  write_n     in   1         active-low write strobe
//  writedata   in   32        write data; bits above field width ignored
//  readdata    out  32        registered read data, zero-extended
//  irq         out  1         OR over channels of (TO & ITO)
//  tick_out    out  CHANNELS  one-cycle pulse per channel timeout
// BEHAVIOUR
//  Clock/reset: one clock; reset asynchronous, active-low; all state to defaults on reset_n=0.
//  Reset values: readdata=0, irq=0, tick_out=0, RUN=0, TO=0, CONTROL=0, PERIOD=RESET_PERIOD,
//   PRESCALE=0, counter=RESET_PERIOD, prescale count=0, snapshot=0.
//  Map, channel c at base 4c: +0 STATUS (r: bit0 TO, bit1 RUN; any write clears TO)
//   +1 CONTROL (bit0 ITO, bit1 CONT stored; bit2 START, bit3 STOP strobes only, read 0)
//   +2 PERIOD (COUNT_W)  +3 PRESCALE (PRESC_W, divide by value+1).
//  Global 4*CHANNELS+0 IRQ_PEND (r only, bit c = TO_c & ITO_c);
//   4*CHANNELS+1 SNAP (write: capture counter of channel writedata[2:0]; read: snapshot).
//  Writes need chipselect=1 & write_n=0; take effect at the clock edge ending that cycle.
//  Reads: readdata updated every cycle from address; 1-cycle latency; unmapped address reads 0.
//  Channel FSM: STOPPED <-> RUNNING (RUN bit).
//   STOPPED->RUNNING on START; RUNNING->STOPPED on STOP, PERIOD/PRESCALE write,
//   or timeout with CONT=0. START and STOP together: START wins.
//  Prescaler: while RUNNING, presc count decrements each cycle; at 0 it emits a tick and
//   reloads PRESCALE. Counter acts only on ticks.
//  Tick: counter==0 -> timeout event, counter<=PERIOD; else counter<=counter-1.
//   So a timeout occurs every (PERIOD+1)*(PRESCALE+1) cycles; PERIOD=0 -> every tick.
//  Timeout event: TO<=1; tick_out[c]=1 the following cycle for exactly one cycle.
//  STATUS write coincident with timeout event: event wins, TO stays 1 (no lost IRQ).
//  PERIOD/PRESCALE write: next cycle counter<=new PERIOD, presc count<=PRESCALE, RUN<=0,
//   no timeout event generated. Write while STOPPED: same reload.
//  One-shot (CONT=0): on timeout RUN clears, counter reloaded to PERIOD, ready for next START.
//  START while RUNNING: no effect on counter (no restart).
//  irq combinational from registered TO/ITO; clearing ITO deasserts irq, TO kept.
//  Arithmetic: counter unsigned COUNT_W, never wraps below 0 (reload at 0).
//  SNAP index >= CHANNELS: snapshot <= 0.
// TESTING
//  1 Reset: all channels read STATUS=0, CONTROL=0, PERIOD=99999; irq=0, tick_out=0.
//  2 ch0 PERIOD=4, PRESCALE=0, CONTROL=0x7 -> tick_out[0] every 5 cycles; irq=1 after first,
//    holds until STATUS write; IRQ_PEND=0x1.
//  3 ch1 PERIOD=2, PRESCALE=3, CONTROL=0x5 -> single timeout 12 cycles after START; RUN=0;
//    SNAP write 1 then read -> 2.
//  4 STATUS write in same cycle as ch0 timeout -> TO remains 1, irq stays 1.
//  5 PERIOD=10 written mid-count while RUNNING -> RUN=0 next cycle, SNAP reads 10, no tick_out.
//  6 reset_n low mid-count, between edges -> readdata, irq, tick_out, RUN go 0 immediately;
//    registers read defaults after release.

Source files
------------

// File: rtl/sensor_timer_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : sensor_timer_mc_if
// Purpose  : Avalon-MM slave bus bundle for the multi-channel sensor timer.
//            The master drives address, chipselect, write_n and writedata.
//            The slave returns registered readdata.
// Revision : 1.0  initial release
// ============================================================================
interface sensor_timer_mc_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/sensor_timer_mc.sv
`default_nettype none
// ============================================================================
// Module   : sensor_timer_mc
// Purpose  : Multi-channel Avalon-MM interval timer. Each channel has:
//            - a prescaled down-counter,
//            - a one-shot or continuous mode,
//            - a sticky timeout flag (TO) with an interrupt enable (ITO),
//            - a one-cycle tick_out pulse on every timeout.
//            The block also provides an aggregated irq, a pending-IRQ
//            summary register and a counter snapshot register.
// Revision : 1.0  initial release
// ============================================================================
module sensor_timer_mc #(
  parameter int CHANNELS     = 2,
  parameter int COUNT_W      = 32,
  parameter int PRESC_W      = 16,
  parameter int ADDR_W       = 4,
  parameter int RESET_PERIOD = 99999
) (
  input  logic                clk,
  input  logic                reset_n,
  sensor_timer_mc_if.slave    bus,
  output logic                irq,
  output logic [CHANNELS-1:0] tick_out
);

  // Global register word addresses sit just past the last channel block.
  localparam logic [ADDR_W-1:0]  c_addr_pend    = ADDR_W'(4 * CHANNELS);
  localparam logic [ADDR_W-1:0]  c_addr_snap    = ADDR_W'(4 * CHANNELS + 1);
  localparam logic [COUNT_W-1:0] c_reset_period = COUNT_W'(RESET_PERIOD);

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  logic                              w_wr;
  logic [ADDR_W-3:0]                 w_ch_sel;
  logic [1:0]                        w_off;
  logic [CHANNELS-1:0]               w_to;
  logic [CHANNELS-1:0]               w_ito;
  logic [CHANNELS-1:0]               w_cont;
  logic [CHANNELS-1:0]               w_run;
  logic [CHANNELS-1:0][COUNT_W-1:0]  w_cnt_all;
  logic [CHANNELS-1:0][COUNT_W-1:0]  w_period_all;
  logic [CHANNELS-1:0][PRESC_W-1:0]  w_presc_all;
  logic [COUNT_W-1:0]                w_snap_sel;
  logic [31:0]                       w_rdata;
  logic [COUNT_W-1:0]                r_snap;
  logic [31:0]                       r_readdata;

  assign w_wr     = bus.chipselect & ~bus.write_n;
  assign w_ch_sel = bus.address[ADDR_W-1:2];
  assign w_off    = bus.address[1:0];

  genvar c;
  for (c = 0; c < CHANNELS; c++) begin : g_ch
    state_t              r_state;
    state_t              w_state_next;
    logic                r_to;
    logic                r_ito;
    logic                r_cont;
    logic                r_tick;
    logic [COUNT_W-1:0]  r_period;
    logic [COUNT_W-1:0]  r_cnt;
    logic [PRESC_W-1:0]  r_presc;
    logic [PRESC_W-1:0]  r_pcnt;
    logic                w_sel;
    logic                w_wr_status;
    logic                w_wr_ctrl;
    logic                w_wr_period;
    logic                w_wr_presc;
    logic                w_reload;
    logic                w_start;
    logic                w_stop;
    logic                w_tick;
    logic                w_timeout;

    assign w_sel       = w_wr && (int'(w_ch_sel) == c);
    assign w_wr_status = w_sel && (w_off == 2'd0);
    assign w_wr_ctrl   = w_sel && (w_off == 2'd1);
    assign w_wr_period = w_sel && (w_off == 2'd2);
    assign w_wr_presc  = w_sel && (w_off == 2'd3);
    assign w_start     = w_wr_ctrl & bus.writedata[2];
    assign w_stop      = w_wr_ctrl & bus.writedata[3];
    assign w_reload    = w_wr_period | w_wr_presc;

    // A PERIOD/PRESCALE write overrides any tick in the same cycle, so a
    // reload never produces a timeout event.
    assign w_tick    = (r_state == ST_RUNNING) && (r_pcnt == '0) && !w_reload;
    assign w_timeout = w_tick && (r_cnt == '0);

    // Next-state logic: START beats STOP; START while running changes nothing.
    always_comb begin
      w_state_next = r_state;
      case (r_state)
        ST_STOPPED: begin
          if (w_start) w_state_next = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (w_reload)                 w_state_next = ST_STOPPED;
          else if (w_stop && !w_start)  w_state_next = ST_STOPPED;
          else if (w_timeout && !r_cont) w_state_next = ST_STOPPED;
        end
        default: w_state_next = ST_STOPPED;
      endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_STOPPED;
      else          r_state <= w_state_next;
    end

    // Control, flag, prescaler and counter datapath.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_to     <= 1'b0;
        r_ito    <= 1'b0;
        r_cont   <= 1'b0;
        r_tick   <= 1'b0;
        r_period <= c_reset_period;
        r_cnt    <= c_reset_period;
        r_presc  <= '0;
        r_pcnt   <= '0;
      end else begin
        if (w_wr_ctrl) begin
          r_ito  <= bus.writedata[0];
          r_cont <= bus.writedata[1];
        end
        // A timeout in the same cycle as a STATUS write keeps TO set.
        if (w_timeout)        r_to <= 1'b1;
        else if (w_wr_status) r_to <= 1'b0;
        r_tick <= w_timeout;
        if (w_wr_period) begin
          r_period <= bus.writedata[COUNT_W-1:0];
          r_cnt    <= bus.writedata[COUNT_W-1:0];
          r_pcnt   <= r_presc;
        end else if (w_wr_presc) begin
          r_presc <= bus.writedata[PRESC_W-1:0];
          r_pcnt  <= bus.writedata[PRESC_W-1:0];
          r_cnt   <= r_period;
        end else if (r_state == ST_RUNNING) begin
          if (r_pcnt == '0) begin
            r_pcnt <= r_presc;
            r_cnt  <= (r_cnt == '0) ? r_period : r_cnt - COUNT_W'(1);
          end else begin
            r_pcnt <= r_pcnt - PRESC_W'(1);
          end
        end
      end
    end

    assign w_to[c]         = r_to;
    assign w_ito[c]        = r_ito;
    assign w_cont[c]       = r_cont;
    assign w_run[c]        = (r_state == ST_RUNNING);
    assign w_cnt_all[c]    = r_cnt;
    assign w_period_all[c] = r_period;
    assign w_presc_all[c]  = r_presc;
    assign tick_out[c]     = r_tick;
  end

  assign irq = |(w_to & w_ito);

  // Pick the counter named by the SNAP write index; out-of-range yields 0.
  always_comb begin
    w_snap_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(bus.writedata[2:0]) == i) w_snap_sel = w_cnt_all[i];
    end
  end

  // Read mux; unmapped addresses return 0.
  always_comb begin
    w_rdata = '0;
    if (bus.address == c_addr_pend) begin
      w_rdata = 32'(w_to & w_ito);
    end else if (bus.address == c_addr_snap) begin
      w_rdata = 32'(r_snap);
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(w_ch_sel) == i) begin
          case (w_off)
            2'd0:    w_rdata = {30'd0, w_run[i], w_to[i]};
            2'd1:    w_rdata = {30'd0, w_cont[i], w_ito[i]};
            2'd2:    w_rdata = 32'(w_period_all[i]);
            default: w_rdata = 32'(w_presc_all[i]);
          endcase
        end
      end
    end
  end

  // Snapshot capture on SNAP write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_snap <= '0;
    else if (w_wr && (bus.address == c_addr_snap)) r_snap <= w_snap_sel;
  end

  // Registered read data, refreshed every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rdata;
  end

  assign bus.readdata = r_readdata;

endmodule
`default_nettype wire
